// File: rtl/ws28xx_channel_gen.sv
// ws28xx_channel_gen: buffered WS28xx one-wire LED channel; define WS28XX_BIT_CODE_INV_EN for an inverted, idle-high output
module ws28xx_channel_gen #(
  parameter int ADDR_W = 8,
  parameter int BYTES_PER_PIX = 4,
  parameter int TIME_W = 9,
  parameter int RST_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TIME_W-1:0]        reg_t0h_time_i,
  input  logic [TIME_W-1:0]        reg_t0s_time_i,
  input  logic [TIME_W-1:0]        reg_t1h_time_i,
  input  logic [TIME_W-1:0]        reg_t1s_time_i,
  input  logic [RST_W-1:0]         reg_rst_time_i,
  input  logic [ADDR_W:0]          reg_pix_cnt_i,
  input  logic                     ram_wr_en_i,
  input  logic [ADDR_W-1:0]        ram_wr_addr_i,
  input  logic [7:0]               ram_wr_data_i,
  input  logic [BYTES_PER_PIX-1:0] ram_wr_byte_en_i,
  input  logic                     ram_wr_done_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     bit_code_o
);
  localparam int W = 8 * BYTES_PER_PIX;
  localparam int BW = $clog2(W);
`ifdef WS28XX_BIT_CODE_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, HIGH, LOW, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem [2**ADDR_W];
  logic [W-1:0] rd_data_q, sh_q, sh_d, nw;
  logic [BW-1:0] bit_q, bit_d;
  logic [TIME_W-1:0] cnt_q, cnt_d, lo_q, lo_d, th, ts;
  logic [RST_W-1:0] gap_q, gap_d;
  logic [ADDR_W:0] left_q, left_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, code_q, code_d;
  logic start_bit, enter_gap;
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BYTES_PER_PIX; k++)
      if (ram_wr_en_i && ram_wr_byte_en_i[k]) mem[ram_wr_addr_i][8*k+:8] <= ram_wr_data_i;
    if (rd_en_q) rd_data_q <= mem[rd_addr_q];
  end
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    lo_d = lo_q;
    gap_d = gap_q;
    left_d = left_q;
    rd_addr_d = rd_addr_q;
    rd_en_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    code_d = code_q;
    start_bit = 1'b0;
    enter_gap = 1'b0;
    nw = rd_data_q;
    case (state_q)
      IDLE: if (ram_wr_done_i) begin
        left_d = reg_pix_cnt_i;
        busy_d = 1'b1;
        rd_addr_d = '0;
        if (reg_pix_cnt_i == '0) enter_gap = 1'b1;
        else begin
          state_d = FETCH;
          rd_en_d = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        start_bit = 1'b1;
        bit_d = BW'(W - 1);
        left_d = left_q - 1'b1;
      end
      HIGH: if (cnt_q == '0) begin
        state_d = LOW;
        cnt_d = lo_q;
        code_d = 1'b0;
      end else cnt_d = cnt_q - 1'b1;
      LOW: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (bit_q != '0) begin
        start_bit = 1'b1;
        nw = sh_q << 1;
        bit_d = bit_q - 1'b1;
      end else if (left_q != '0) begin
        start_bit = 1'b1;
        bit_d = BW'(W - 1);
        left_d = left_q - 1'b1;
      end else enter_gap = 1'b1;
      GAP: if (gap_q == '0) begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else gap_d = gap_q - 1'b1;
      default: state_d = IDLE;
    endcase
    th = nw[W-1] ? reg_t1h_time_i : reg_t0h_time_i;
    ts = nw[W-1] ? reg_t1s_time_i : reg_t0s_time_i;
    // counters hold remaining cycles minus one so a zero high time still yields one cycle
    if (start_bit) begin
      state_d = HIGH;
      sh_d = nw;
      code_d = 1'b1;
      cnt_d = th == '0 ? '0 : th - 1'b1;
      lo_d = ts > th ? ts - th - 1'b1 : '0;
      if (bit_d == '0) begin
        rd_en_d = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
    if (enter_gap) begin
      if (reg_rst_time_i == '0) begin
        state_d = DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        state_d = GAP;
        gap_d = reg_rst_time_i - 1'b1;
        code_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      lo_q <= '0;
      gap_q <= '0;
      left_q <= '0;
      rd_addr_q <= '0;
      rd_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      code_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      lo_q <= lo_d;
      gap_q <= gap_d;
      left_q <= left_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q <= rd_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      code_q <= code_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bit_code_o = code_q ^ INV;
endmodule

// File: tb/tb_ws28xx_channel_gen.sv
// tb_ws28xx_channel_gen: randomized scoreboard bench comparing the serial waveform cycle by cycle
module tb_ws28xx_channel_gen;
  localparam int ADDR_W = 4, BPP = 4, TIME_W = 9, RST_W = 16;
  localparam int W = 8 * BPP, DEPTH = 1 << ADDR_W;
`ifdef WS28XX_BIT_CODE_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  logic clk = 1'b0, rst_i = 1'b1;
  logic [TIME_W-1:0] t0h = '0, t0s = '0, t1h = '0, t1s = '0;
  logic [RST_W-1:0] rstt = '0;
  logic [ADDR_W:0] pix_cnt = '0;
  logic wr_en = 1'b0, start = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [BPP-1:0] wr_be = '0;
  logic busy_o, done_o, bit_code_o;
  logic [W-1:0] model [DEPTH];
  logic [2:0] exp_q [$];
  logic [2:0] e_v, a_v;
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  ws28xx_channel_gen #(.ADDR_W(ADDR_W), .BYTES_PER_PIX(BPP), .TIME_W(TIME_W), .RST_W(RST_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .reg_t0h_time_i(t0h), .reg_t0s_time_i(t0s), .reg_t1h_time_i(t1h), .reg_t1s_time_i(t1s),
    .reg_rst_time_i(rstt), .reg_pix_cnt_i(pix_cnt),
    .ram_wr_en_i(wr_en), .ram_wr_addr_i(wr_addr), .ram_wr_data_i(wr_data), .ram_wr_byte_en_i(wr_be),
    .ram_wr_done_i(start), .busy_o(busy_o), .done_o(done_o), .bit_code_o(bit_code_o)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      e_v = 3'b000;
      if (exp_q.size() > 0) e_v = exp_q.pop_front();
      a_v = {busy_o, done_o, bit_code_o ^ INV};
      checks++;
      if (a_v !== e_v) begin
        errors++;
        if (errors <= 25) $display("FAIL wave at %0t: busy/done/code got %b required %b", $time, a_v, e_v);
      end
    end
  end
  task automatic wr_byte(input int a, input logic [7:0] d, input logic [BPP-1:0] be);
    wr_en = 1'b1;
    wr_addr = a[ADDR_W-1:0];
    wr_data = d;
    wr_be = be;
    for (int k = 0; k < BPP; k++) if (be[k]) model[a][8*k+:8] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wr_word(input int a, input logic [W-1:0] w);
    for (int k = 0; k < BPP; k++) wr_byte(a, w[8*k+:8], BPP'(1 << k));
  endtask
  task automatic set_t(input int a, input int b, input int c, input int d, input int r);
    t0h = TIME_W'(a);
    t0s = TIME_W'(b);
    t1h = TIME_W'(c);
    t1s = TIME_W'(d);
    rstt = RST_W'(r);
  endtask
  task automatic push_frame(input int n);
    int h, s, hi, lo;
    if (n > 0) repeat (2) exp_q.push_back(3'b100);
    for (int p = 0; p < n; p++)
      for (int b = W - 1; b >= 0; b--) begin
        h = model[p][b] ? int'(t1h) : int'(t0h);
        s = model[p][b] ? int'(t1s) : int'(t0s);
        hi = h < 1 ? 1 : h;
        lo = s > h ? s - h : 1;
        repeat (hi) exp_q.push_back(3'b101);
        repeat (lo) exp_q.push_back(3'b100);
      end
    repeat (int'(rstt)) exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
  endtask
  task automatic start_frame(input int n);
    pix_cnt = n[ADDR_W:0];
    start = 1'b1;
    push_frame(n);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL wait expired at %0t: %0d expected cycles pending", $time, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, bit_code_o} !== {1'b0, 1'b0, INV}) begin
      errors++;
      $display("FAIL reset state at %0t: busy/done/code got %b%b%b", $time, busy_o, done_o, bit_code_o);
    end
    rst_i = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    for (int a = 0; a < DEPTH; a++) wr_word(a, '0);
    wr_word(0, 32'h8000_0001);
    set_t(3, 10, 7, 10, 20);
    start_frame(1);
    wait_idle();
    wr_word(0, 32'hFFFF_FFFF);
    wr_word(1, 32'h0000_0000);
    wr_word(2, 32'hAAAA_AAAA);
    start_frame(3);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_word(10, 32'h1234_5678);
    wait_idle();
    set_t(3, 10, 7, 10, 5);
    start_frame(0);
    wait_idle();
    set_t(3, 10, 7, 10, 0);
    start_frame(0);
    wait_idle();
    set_t(3, 10, 7, 10, 20);
    start_frame(3);
    repeat (45) @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    start_frame(2);
    wait_idle();
    set_t(3, 10, 12, 10, 4);
    start_frame(1);
    wait_idle();
    set_t(0, 2, 2, 3, 3);
    start_frame(DEPTH);
    wait_idle();
    for (int f = 0; f < 8; f++) begin
      for (int a = 0; a < DEPTH; a++) wr_byte(a, 8'($urandom), BPP'($urandom));
      set_t($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 12));
      start_frame($urandom_range(0, DEPTH));
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
